// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port round-robin memory arbiter.
package mem_arb_pkg;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned PERF_W  = 16;
   localparam int unsigned STATE_W = 2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   typedef logic [STATE_W-1:0] state_t;
   typedef logic               req_id_t;

   // One-hot grant vector for a requester id
   function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; slave = arbiter, master = clients/memory.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  r0_valid, r0_ready, r0_we, r0_rsp_valid;
   logic [ADDR_WIDTH-1:0] r0_addr;
   logic [DATA_WIDTH-1:0] r0_wdata, r0_rsp_rdata;
   logic                  r1_valid, r1_ready, r1_we, r1_rsp_valid;
   logic [ADDR_WIDTH-1:0] r1_addr;
   logic [DATA_WIDTH-1:0] r1_wdata, r1_rsp_rdata;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_wr_en, mem_rd_en;
   logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
   logic [PERF_W-1:0]     perf_grant0, perf_grant1;

   modport slave (
      input  r0_valid, r0_we, r0_addr, r0_wdata,
      input  r1_valid, r1_we, r1_addr, r1_wdata,
      input  mem_rdata,
      output r0_ready, r0_rsp_valid, r0_rsp_rdata,
      output r1_ready, r1_rsp_valid, r1_rsp_rdata,
      output mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
      output perf_grant0, perf_grant1
   );

   modport master (
      output r0_valid, r0_we, r0_addr, r0_wdata,
      output r1_valid, r1_we, r1_addr, r1_wdata,
      output mem_rdata,
      input  r0_ready, r0_rsp_valid, r0_rsp_rdata,
      input  r1_ready, r1_rsp_valid, r1_rsp_rdata,
      input  mem_addr, mem_wr_en, mem_rd_en, mem_wdata,
      input  perf_grant0, perf_grant1
   );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick favouring the port that did not win last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  req_id_t            last_grant,
   output logic [NUM_REQ-1:0] grant,
   output req_id_t            grant_id
);

   always_comb begin
      grant_id = 1'b0;
      grant    = '0;
      case (valid)
         2'b01:   grant_id = 1'b0;
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~last_grant;
         default: grant_id = 1'b0;
      endcase
      if (|valid) grant = id_to_onehot(grant_id);
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between two requesters.
// Optional per-port grant counters are built when MEM_ARB_PERF_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
)(
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   state_t                state_q, state_d;
   req_id_t               last_grant_q, gnt_id_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic                  mem_wr_en_q, mem_rd_en_q;
   logic                  rsp_valid0_q, rsp_valid1_q;
   logic [DATA_WIDTH-1:0] rsp_rdata0_q, rsp_rdata1_q;

   logic [NUM_REQ-1:0]    valid_c, grant_c;
   req_id_t               grant_id_c;
   logic                  idle_c, hs_c, sel_we_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_wdata_c, rsp_data_c;

   assign valid_c = {bus.r1_valid, bus.r0_valid};

   rr_arb2 u_rr_arb2 (
      .valid      (valid_c),
      .last_grant (last_grant_q),
      .grant      (grant_c),
      .grant_id   (grant_id_c)
   );

   assign idle_c       = (state_q == ST_IDLE);
   assign hs_c         = idle_c && (|valid_c);
   assign bus.r0_ready = idle_c && grant_c[0];
   assign bus.r1_ready = idle_c && grant_c[1];

   assign sel_we_c    = grant_id_c ? bus.r1_we    : bus.r0_we;
   assign sel_addr_c  = grant_id_c ? bus.r1_addr  : bus.r0_addr;
   assign sel_wdata_c = grant_id_c ? bus.r1_wdata : bus.r0_wdata;
   assign rsp_data_c  = we_q ? '0 : bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Only IDLE waits; the access pipeline always runs to completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (hs_c) state_d = ST_ACCESS;
         ST_ACCESS: state_d = ST_WAIT;
         ST_WAIT:   state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         gnt_id_q     <= 1'b0;
         we_q         <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wr_en_q  <= 1'b0;
         mem_rd_en_q  <= 1'b0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         rsp_rdata0_q <= '0;
         rsp_rdata1_q <= '0;
      end else begin
         mem_wr_en_q  <= 1'b0;
         mem_rd_en_q  <= 1'b0;
         rsp_valid0_q <= 1'b0;
         rsp_valid1_q <= 1'b0;
         if (hs_c) begin
            last_grant_q <= grant_id_c;
            gnt_id_q     <= grant_id_c;
            we_q         <= sel_we_c;
            mem_addr_q   <= sel_addr_c;
            mem_wdata_q  <= sel_wdata_c;
            mem_wr_en_q  <= sel_we_c;
            mem_rd_en_q  <= !sel_we_c;
         end
         // Memory read data is valid during WAIT; it becomes the response next cycle
         if (state_q == ST_WAIT) begin
            if (gnt_id_q) begin
               rsp_rdata1_q <= rsp_data_c;
               rsp_valid1_q <= 1'b1;
            end else begin
               rsp_rdata0_q <= rsp_data_c;
               rsp_valid0_q <= 1'b1;
            end
         end
      end
   end

   assign bus.mem_addr     = mem_addr_q;
   assign bus.mem_wdata    = mem_wdata_q;
   assign bus.mem_wr_en    = mem_wr_en_q;
   assign bus.mem_rd_en    = mem_rd_en_q;
   assign bus.r0_rsp_valid = rsp_valid0_q;
   assign bus.r1_rsp_valid = rsp_valid1_q;
   assign bus.r0_rsp_rdata = rsp_rdata0_q;
   assign bus.r1_rsp_rdata = rsp_rdata1_q;

`ifdef MEM_ARB_PERF_EN
   logic [PERF_W-1:0] perf0_q, perf1_q;

   // Saturating per-port handshake counters
   always_ff @(posedge clk) begin
      if (reset) begin
         perf0_q <= '0;
         perf1_q <= '0;
      end else if (hs_c) begin
         if (!grant_id_c && (perf0_q != '1)) perf0_q <= perf0_q + PERF_W'(1);
         if ( grant_id_c && (perf1_q != '1)) perf1_q <= perf1_q + PERF_W'(1);
      end
   end

   assign bus.perf_grant0 = perf0_q;
   assign bus.perf_grant1 = perf1_q;
`else
   assign bus.perf_grant0 = '0;
   assign bus.perf_grant1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard queues and a behavioural memory.
module tb_mem_arbiter;

   typedef struct {
      bit         port;
      bit         we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;

   typedef struct { logic [7:0] rdata; int cyc; } rsp_exp_t;
   typedef struct { bit we; logic [3:0] addr; logic [7:0] wdata; int cyc; } acc_exp_t;
   typedef struct { bit port; int cyc; } gnt_t;

   logic clk = 1'b0;
   logic reset;
   logic mem_clear;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   bit   hs0, hs1;
   logic [7:0] exp_rd [2];

   rsp_exp_t q0[$], q1[$];
   acc_exp_t memq[$];
   gnt_t     glog[$];
   vec_t     vecs[9];

   logic [7:0] mem_arr [16];
   logic [7:0] mem_rdata_q;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

   mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Single-port synchronous memory, registered read, 1-cycle latency
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 16; i++) mem_arr[i] <= 8'hFF;
      end else begin
         if (bus.mem_wr_en) mem_arr[bus.mem_addr] <= bus.mem_wdata;
         if (bus.mem_rd_en) mem_rdata_q <= mem_arr[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = mem_rdata_q;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Sampled on the falling edge: handshakes, memory strobes and responses
   task automatic mon();
      acc_exp_t a;
      rsp_exp_t r;
      hs0 = 1'b0;
      hs1 = 1'b0;
      if (!reset) begin
         check_eq("ready_exclusive", 32'(bus.r0_ready && bus.r1_ready), 0);
         hs0 = bus.r0_valid && bus.r0_ready;
         hs1 = bus.r1_valid && bus.r1_ready;
         if (hs0) begin
            q0.push_back('{exp_rd[0], cyc});
            memq.push_back('{bus.r0_we, bus.r0_addr, bus.r0_wdata, cyc});
            glog.push_back('{1'b0, cyc});
         end
         if (hs1) begin
            q1.push_back('{exp_rd[1], cyc});
            memq.push_back('{bus.r1_we, bus.r1_addr, bus.r1_wdata, cyc});
            glog.push_back('{1'b1, cyc});
         end
         if (bus.mem_wr_en || bus.mem_rd_en) begin
            check_eq("mem_strobe_expected", 32'(memq.size() != 0), 1);
            if (memq.size() != 0) begin
               a = memq.pop_front();
               check_eq("mem_wr_en", 32'(bus.mem_wr_en), 32'(a.we));
               check_eq("mem_rd_en", 32'(bus.mem_rd_en), 32'(!a.we));
               check_eq("mem_addr", 32'(bus.mem_addr), 32'(a.addr));
               if (a.we) check_eq("mem_wdata", 32'(bus.mem_wdata), 32'(a.wdata));
               check_eq("mem_strobe_cycle", 32'(cyc), 32'(a.cyc + 1));
            end
         end
         if (bus.r0_rsp_valid) begin
            check_eq("r0_rsp_expected", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
               r = q0.pop_front();
               check_eq("r0_rsp_rdata", 32'(bus.r0_rsp_rdata), 32'(r.rdata));
               check_eq("r0_rsp_cycle", 32'(cyc), 32'(r.cyc + 3));
            end
         end
         if (bus.r1_rsp_valid) begin
            check_eq("r1_rsp_expected", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
               r = q1.pop_front();
               check_eq("r1_rsp_rdata", 32'(bus.r1_rsp_rdata), 32'(r.rdata));
               check_eq("r1_rsp_cycle", 32'(cyc), 32'(r.cyc + 3));
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      mon();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drive(input bit p, input bit v, input bit we, input logic [3:0] a,
                        input logic [7:0] d);
      if (p) begin
         bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
      end else begin
         bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
      end
   endtask

   task automatic issue(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] exp);
      bit got = 1'b0;
      exp_rd[p] = exp;
      drive(p, 1'b1, we, a, d);
      for (int i = 0; i < 16 && !got; i++) begin
         tick();
         got = p ? hs1 : hs0;
      end
      check_eq("handshake_seen", 32'(got), 1);
      drive(p, 1'b0, we, a, d);
   endtask

   task automatic drain();
      for (int i = 0; i < 16 && (q0.size() + q1.size() + memq.size()) != 0; i++) tick();
      check_eq("drain_empty", 32'(q0.size() + q1.size() + memq.size()), 0);
   endtask

   task automatic check_zero(input string tag);
      check_eq({tag, "_ready"},  32'({bus.r1_ready, bus.r0_ready}), 0);
      check_eq({tag, "_rsp_v"},  32'({bus.r1_rsp_valid, bus.r0_rsp_valid}), 0);
      check_eq({tag, "_rsp_d"},  32'({bus.r1_rsp_rdata, bus.r0_rsp_rdata}), 0);
      check_eq({tag, "_mem_ctl"}, 32'({bus.mem_wr_en, bus.mem_rd_en}), 0);
      check_eq({tag, "_mem_a_d"}, 32'({bus.mem_addr, bus.mem_wdata}), 0);
      check_eq({tag, "_perf"},   {bus.perf_grant1, bus.perf_grant0}, 0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
      q0.delete(); q1.delete(); memq.delete(); glog.delete();
   endtask

   initial begin
      logic [15:0] exp_p0, exp_p1;
      vecs[0] = '{1'b0, 1'b1, 4'h3, 8'hA5, 8'h00};
      vecs[1] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hA5};
      vecs[2] = '{1'b0, 1'b0, 4'hF, 8'h00, 8'hFF};
      vecs[3] = '{1'b1, 1'b1, 4'h1, 8'h3C, 8'h00};
      vecs[4] = '{1'b0, 1'b1, 4'h2, 8'hC3, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'hC3};
      vecs[6] = '{1'b1, 1'b0, 4'h1, 8'h00, 8'h3C};
      vecs[7] = '{1'b0, 1'b1, 4'h1, 8'h5A, 8'h00};
      vecs[8] = '{1'b1, 1'b0, 4'h1, 8'h00, 8'h5A};

      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
      mem_clear = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      check_zero("reset");
      do_reset(0);
      mem_clear = 1'b0;

      // Table-driven single transactions
      for (int v = 0; v < 9; v++) begin
         issue(vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rdata);
         drain();
      end

      // Both ports continuously valid: grants alternate 0,1,0,1, four cycles apart
      do_reset(2);
      exp_rd[0] = 8'h5A;
      exp_rd[1] = 8'hC3;
      drive(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
      for (int i = 0; i < 40 && glog.size() < 4; i++) tick();
      drive(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
      check_eq("alt_grant_count", 32'(glog.size()), 4);
      for (int k = 0; k < glog.size(); k++) begin
         check_eq("alt_grant_port", 32'(glog[k].port), 32'(k % 2));
         if (k > 0) check_eq("alt_grant_spacing", 32'(glog[k].cyc - glog[k-1].cyc), 4);
      end
      drain();

      // Reset during WAIT of a read: response abandoned, everything back to zero
      issue(1'b0, 1'b0, 4'h2, 8'h00, 8'hC3);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q0.delete(); q1.delete(); memq.delete(); glog.delete();
      check_zero("wait_reset");
      repeat (4) tick();
      exp_rd[0] = 8'h5A;
      exp_rd[1] = 8'hC3;
      drive(1'b0, 1'b1, 1'b0, 4'h1, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 4'h2, 8'h00);
      for (int i = 0; i < 20 && glog.size() < 1; i++) tick();
      drive(1'b0, 1'b0, 1'b0, 4'h1, 8'h00);
      for (int i = 0; i < 20 && glog.size() < 2; i++) tick();
      drive(1'b1, 1'b0, 1'b0, 4'h2, 8'h00);
      check_eq("post_reset_grants", 32'(glog.size()), 2);
      if (glog.size() > 0) check_eq("post_reset_tie_port", 32'(glog[0].port), 0);
      drain();

      // Grant counters: 3 transactions on port 0, 2 on port 1
      do_reset(2);
      check_eq("perf_after_reset", {bus.perf_grant1, bus.perf_grant0}, 0);
      for (int i = 0; i < 3; i++) begin
         issue(1'b0, 1'b0, 4'h1, 8'h00, 8'h5A);
         drain();
      end
      for (int i = 0; i < 2; i++) begin
         issue(1'b1, 1'b0, 4'h2, 8'h00, 8'hC3);
         drain();
      end
`ifdef MEM_ARB_PERF_EN
      exp_p0 = 16'd3;
      exp_p1 = 16'd2;
`else
      exp_p0 = 16'd0;
      exp_p1 = 16'd0;
`endif
      check_eq("perf_grant0", 32'(bus.perf_grant0), 32'(exp_p0));
      check_eq("perf_grant1", 32'(bus.perf_grant1), 32'(exp_p1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin controller sharing one single-port synchronous memory (addr/wr_en/rd_en/wdata in, registered rdata out, 1-cycle read latency) between two requesters.
- Each requester issues one read or write through a valid/ready handshake and receives a one-cycle response pulse.
- The arbiter drives all memory control/data inputs from registers and captures memory read data.
- Sits between the memory and two bus-side clients, e.g. a host port and a DMA/test port.

Parameters:
ADDR_WIDTH, 4, memory address width; must match the memory instance.
DATA_WIDTH, 8, memory data width; must match the memory instance.

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
rN_valid  in  1  requester N (N=0,1) has a request
rN_ready  out  1  request of N accepted this cycle
rN_we  in  1  1=write, 0=read
rN_addr  in  ADDR_WIDTH  request address
rN_wdata  in  DATA_WIDTH  write data
rN_rsp_valid  out  1  one-cycle response pulse to N (read data or write ack)
rN_rsp_rdata  out  DATA_WIDTH  read data; 0 for write ack
mem_addr  out  ADDR_WIDTH  to memory addr
mem_wr_en  out  1  to memory wr_en
mem_rd_en  out  1  to memory rd_en
mem_wdata  out  DATA_WIDTH  to memory wdata
mem_rdata  in  DATA_WIDTH  from memory rdata
perf_grant0, perf_grant1  out  16  grant counters (see Optional Feature)

Behaviour:
- Reset (sync, active-high): state=IDLE, last_grant=1 (port 0 wins first tie). All outputs 0: ready, rsp_valid, rsp_rdata, all mem_* signals, perf counters.
- FSM states: IDLE -> ACCESS -> WAIT -> RESP -> IDLE. Transitions are unconditional except IDLE.
- IDLE:
  - Arbitrate combinationally. If only one valid, grant it. If both valid, grant the port != last_grant.
  - rN_ready=1 only for the granted port, only in IDLE. Never asserted to both ports.
  - Handshake = valid & ready at edge T. On that edge register addr/we/wdata/granted id, set mem_wr_en=we, mem_rd_en=!we, update last_grant, go ACCESS.
  - No valid: stay IDLE.
- ACCESS (cycle T+1): mem strobes high for exactly this cycle; memory samples at edge T+1. Strobes cleared at that edge. Go WAIT.
- WAIT (cycle T+2): mem_rdata valid. For a read, capture it into the granted port's rsp_rdata at edge T+2. For a write, load 0. Go RESP.
- RESP (cycle T+3): granted port's rsp_valid=1 for one cycle; the other port's rsp_valid stays 0. rsp_rdata holds until the next response to that port. Go IDLE.
- Throughput: one transaction per 4 cycles; the next handshake can occur at T+4 earliest. Responses have no backpressure.
- mem_addr/mem_wdata hold their last value outside ACCESS. Only the strobes matter.
- Requester inputs are ignored outside IDLE. A requester holds valid and fields stable until ready.
- Reset in any state: in-flight transaction abandoned, no rsp_valid issued. A write in ACCESS at the reset edge is not guaranteed to land.
- Same-address write then read (either port) returns the new data (serialized, no hazard).

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined: perf_grantN increments by 1 on each handshake for port N, saturating at 16'hFFFF. Cleared by reset.
- Undefined: counters not built; perf_grant0/1 tied to 0. Port list is unchanged.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS, WAIT, RESP}
  - requester-id typedef (1 bit)
  - NUM_REQ=2
  - PERF_W=16
- Sub-module rr_arb2: combinational 2-way round-robin pick.
  - Inputs: valid[1:0], last_grant.
  - Outputs: grant one-hot, grant_id.

Test Plan:
- Reset then r0 write addr 4'h3 data 8'hA5 -> mem_wr_en high exactly one cycle at T+1 with addr 3/data A5. r0_rsp_valid pulse at T+3 with rdata 0.
- r0 read addr 3 after the write above -> mem_rd_en at T+1; r0_rsp_valid at T+3 with r0_rsp_rdata=8'hA5; r1_rsp_valid stays 0.
- r0 and r1 both valid continuously (reads of addr 1 and 2) -> grants alternate 0,1,0,1 with handshakes 4 cycles apart; responses route to correct port.
- Read of never-written addr 4'hF after memory reset -> rsp_rdata=8'hFF.
- Reset asserted in WAIT of a read -> no rsp_valid, all outputs 0 next cycle, state IDLE; next request serviced normally by port 0 on a tie.
- With MEM_ARB_PERF_EN: 3 r0 + 2 r1 transactions -> perf_grant0=3, perf_grant1=2. Without the macro -> both read 0.
